// File: rtl/counter_ctrl.sv
// counter_ctrl: debounced button sequencer driving an 8-bit up/down counter.
// Ports: clk, rst (sync, active-high); btn_run/step/dir/sel raw buttons;
//        s0 dir (1=up), s1 hold (0=count), s2 display select,
//        cnt_en count pulse (= ~s1), state (00 STOP, 01 RUN, 10 STEP).
module counter_ctrl #(
   parameter int TICK_DIV = 25_000_000,
   parameter int DEB_CNT  = 250_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_run,
   input  logic       btn_step,
   input  logic       btn_dir,
   input  logic       btn_sel,
   output logic       s0,
   output logic       s1,
   output logic       s2,
   output logic       cnt_en,
   output logic [1:0] state
);

   localparam int DW = $clog2(DEB_CNT + 1);
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CNT);
   localparam logic [TW-1:0] DIV_MAX = TW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      ST_STOP = 2'b00,
      ST_RUN  = 2'b01,
      ST_STEP = 2'b10
   } state_t;

   // Bit order for all per-button vectors: {sel, dir, step, run}
   logic [3:0]    btn_raw;
   logic [3:0]    sync1_q, sync2_q;
   logic [3:0]    stable_q, stable_d;
   logic [3:0]    prev_q;
   logic [3:0]    press_q, press_d;
   logic [DW-1:0] deb_q [4];
   logic [DW-1:0] deb_d [4];

   state_t        state_q, state_d;
   logic [TW-1:0] div_q, div_d;
   logic          cnt_en_q, cnt_en_d;
   logic          dir_q, dir_d;
   logic          sel_q, sel_d;

   logic          press_run, press_step, press_dir, press_sel;

   assign btn_raw = {btn_sel, btn_dir, btn_step, btn_run};

   // The mismatch counter is allowed to hold DEB_CNT; the stable level
   // flips on the next mismatching sample after that.
   always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < 4; i++) begin
         deb_d[i] = '0;
         if (sync2_q[i] != stable_q[i]) begin
            if (deb_q[i] == DEB_MAX) begin
               stable_d[i] = sync2_q[i];
            end else begin
               deb_d[i] = deb_q[i] + 1'b1;
            end
         end
      end
      press_d = stable_q & ~prev_q;
   end

   assign press_run  = press_q[0];
   assign press_step = press_q[1];
   assign press_dir  = press_q[2];
   assign press_sel  = press_q[3];

   always_comb begin
      state_d = state_q;
      div_d   = '0;
      dir_d   = dir_q ^ press_dir;
      sel_d   = sel_q ^ press_sel;
      unique case (state_q)
         ST_STOP: begin
            if (press_run) begin
               state_d = ST_RUN;
            end else if (press_step) begin
               state_d = ST_STEP;
            end
         end
         ST_RUN: begin
            if (press_run) begin
               state_d = ST_STOP;
            end else if (div_q != DIV_MAX) begin
               div_d = div_q + 1'b1;
            end
         end
         ST_STEP: state_d = ST_STOP;
         default: state_d = ST_STOP;
      endcase
      // A run press on the tick cycle stops without a final step.
      cnt_en_d = (state_d == ST_STEP) ||
                 ((state_q == ST_RUN) && (div_q == DIV_MAX) && !press_run);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         stable_q <= '0;
         prev_q   <= '0;
         press_q  <= '0;
         for (int i = 0; i < 4; i++) begin
            deb_q[i] <= '0;
         end
         state_q  <= ST_STOP;
         div_q    <= '0;
         cnt_en_q <= 1'b0;
         dir_q    <= 1'b1;
         sel_q    <= 1'b0;
      end else begin
         sync1_q  <= btn_raw;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         prev_q   <= stable_q;
         press_q  <= press_d;
         for (int i = 0; i < 4; i++) begin
            deb_q[i] <= deb_d[i];
         end
         state_q  <= state_d;
         div_q    <= div_d;
         cnt_en_q <= cnt_en_d;
         dir_q    <= dir_d;
         sel_q    <= sel_d;
      end
   end

   assign s0     = dir_q;
   assign s1     = ~cnt_en_q;
   assign s2     = sel_q;
   assign cnt_en = cnt_en_q;
   assign state  = state_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl: directed bench for counter_ctrl (TICK_DIV=5, DEB_CNT=4)
// with an attached 8-bit up/down counter model driven by s0/s1/s2.
module tb_counter_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_run, btn_step, btn_dir, btn_sel;
   logic       s0, s1, s2, cnt_en;
   logic [1:0] state;

   logic [7:0] ctr;
   logic [7:0] out0, out1;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   counter_ctrl #(
      .TICK_DIV(5),
      .DEB_CNT (4)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .btn_run (btn_run),
      .btn_step(btn_step),
      .btn_dir (btn_dir),
      .btn_sel (btn_sel),
      .s0      (s0),
      .s1      (s1),
      .s2      (s2),
      .cnt_en  (cnt_en),
      .state   (state)
   );

   // Attached display counter
   always @(posedge clk) begin
      if (rst) ctr <= 8'd0;
      else if (!s1) ctr <= s0 ? ctr + 8'd1 : ctr - 8'd1;
   end
   assign out0 = s2 ? 8'd0 : ctr;
   assign out1 = s2 ? ctr : 8'd0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_btns(input logic [3:0] m);
      {btn_sel, btn_dir, btn_step, btn_run} = m;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      set_btns(4'b0000);
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Press lands on the edge 9 edges after the buttons go high
   task automatic press(input logic [3:0] m);
      set_btns(m);
      repeat (8) tick();
      set_btns(4'b0000);
      tick();
   endtask

   task automatic test_reset();
      logic [1:0] es;
      logic       e0, e2;
      rst = 1'b1;
      set_btns(4'b1111);
      tick();
      n_checks++;
      if ({s0, s1, s2, cnt_en, state} !== 6'b110000) begin
         n_fail++;
         $display("FAIL reset_first_edge: got s0s1s2en_st=%b want 110000",
                  {s0, s1, s2, cnt_en, state});
      end
      tick();
      n_checks++;
      if ({s0, s1, s2, cnt_en, state} !== 6'b110000) begin
         n_fail++;
         $display("FAIL reset_hold: got %b want 110000",
                  {s0, s1, s2, cnt_en, state});
      end
      rst = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         tick();
         es = (i == 9) ? 2'b01 : 2'b00;
         e0 = (i == 9) ? 1'b0 : 1'b1;
         e2 = (i == 9) ? 1'b1 : 1'b0;
         n_checks++;
         if (state !== es || s0 !== e0 || s2 !== e2) begin
            n_fail++;
            $display("FAIL reset_held_btn edge %0d: st=%b s0=%b s2=%b want %b %b %b",
                     i, state, s0, s2, es, e0, e2);
         end
      end
      n_checks++;
      if (cnt_en !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_held_no_step: cnt_en=%b want 0", cnt_en);
      end
      do_reset();
   endtask

   task automatic test_debounce();
      logic [1:0] es;
      do_reset();
      btn_run = 1'b1;
      repeat (3) tick();
      btn_run = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         n_checks++;
         if (state !== 2'b00) begin
            n_fail++;
            $display("FAIL glitch_reject cyc %0d: state=%b want 00", i, state);
         end
      end
      btn_run = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         es = (i >= 9) ? 2'b01 : 2'b00;
         n_checks++;
         if (state !== es) begin
            n_fail++;
            $display("FAIL clean_press edge %0d: state=%b want %b", i, state, es);
         end
      end
      btn_run = 1'b0;
   endtask

   task automatic test_run_cadence();
      logic ee;
      do_reset();
      press(4'b0001);
      n_checks++;
      if (state !== 2'b01) begin
         n_fail++;
         $display("FAIL run_entry: state=%b want 01", state);
      end
      for (int k = 1; k <= 26; k++) begin
         tick();
         ee = (k % 5 == 0);
         n_checks++;
         if (cnt_en !== ee || s1 !== ~ee || state !== 2'b01) begin
            n_fail++;
            $display("FAIL run_tick k=%0d: cnt_en=%b s1=%b st=%b want %b %b 01",
                     k, cnt_en, s1, state, ee, ~ee);
         end
      end
      n_checks++;
      if (ctr !== 8'd5) begin
         n_fail++;
         $display("FAIL run_count: ctr=%0d want 5", ctr);
      end
      // Run press lands on the tick cycle: stop, no final step
      press(4'b0001);
      n_checks++;
      if (state !== 2'b00 || cnt_en !== 1'b0 || ctr !== 8'd6) begin
         n_fail++;
         $display("FAIL run_stop: st=%b cnt_en=%b ctr=%0d want 00 0 6",
                  state, cnt_en, ctr);
      end
      for (int k = 0; k < 10; k++) begin
         tick();
         n_checks++;
         if (s1 !== 1'b1 || state !== 2'b00) begin
            n_fail++;
            $display("FAIL stop_hold k=%0d: s1=%b st=%b want 1 00", k, s1, state);
         end
      end
   endtask

   task automatic test_step_priority();
      logic ee;
      do_reset();
      press(4'b0010);
      n_checks++;
      if (state !== 2'b10 || cnt_en !== 1'b1 || s1 !== 1'b0) begin
         n_fail++;
         $display("FAIL step_pulse: st=%b cnt_en=%b s1=%b want 10 1 0",
                  state, cnt_en, s1);
      end
      tick();
      n_checks++;
      if (state !== 2'b00 || cnt_en !== 1'b0 || ctr !== 8'd1) begin
         n_fail++;
         $display("FAIL step_done: st=%b cnt_en=%b ctr=%0d want 00 0 1",
                  state, cnt_en, ctr);
      end
      for (int k = 0; k < 10; k++) begin
         tick();
         n_checks++;
         if (cnt_en !== 1'b0 || state !== 2'b00) begin
            n_fail++;
            $display("FAIL step_single k=%0d: cnt_en=%b st=%b", k, cnt_en, state);
         end
      end
      press(4'b0011);
      n_checks++;
      if (state !== 2'b01 || cnt_en !== 1'b0) begin
         n_fail++;
         $display("FAIL run_beats_step: st=%b cnt_en=%b want 01 0", state, cnt_en);
      end
      for (int k = 1; k <= 30; k++) begin
         if (k == 10) btn_step = 1'b1;
         if (k == 20) btn_step = 1'b0;
         tick();
         ee = (k % 5 == 0);
         n_checks++;
         if (state !== 2'b01 || cnt_en !== ee) begin
            n_fail++;
            $display("FAIL step_in_run k=%0d: st=%b cnt_en=%b want 01 %b",
                     k, state, cnt_en, ee);
         end
      end
      n_checks++;
      if (ctr !== 8'd6) begin
         n_fail++;
         $display("FAIL step_in_run_count: ctr=%0d want 6", ctr);
      end
   endtask

   task automatic test_dir_sel();
      do_reset();
      press(4'b0101);
      n_checks++;
      if (state !== 2'b01 || s0 !== 1'b0 || ctr !== 8'd0) begin
         n_fail++;
         $display("FAIL dir_toggle: st=%b s0=%b ctr=%0d want 01 0 0", state, s0, ctr);
      end
      repeat (6) tick();
      n_checks++;
      if (ctr !== 8'd255 || out0 !== 8'd255 || s2 !== 1'b0) begin
         n_fail++;
         $display("FAIL dir_down: ctr=%0d out0=%0d s2=%b want 255 255 0",
                  ctr, out0, s2);
      end
      press(4'b1000);
      n_checks++;
      if (s2 !== 1'b1 || out1 !== 8'd254 || out0 !== 8'd0) begin
         n_fail++;
         $display("FAIL sel_toggle: s2=%b out1=%0d out0=%0d want 1 254 0",
                  s2, out1, out0);
      end
   endtask

   task automatic test_reset_midrun();
      logic ee;
      do_reset();
      press(4'b0001);
      repeat (4) tick();
      n_checks++;
      if (cnt_en !== 1'b0 || state !== 2'b01) begin
         n_fail++;
         $display("FAIL midrun_pre: cnt_en=%b st=%b want 0 01", cnt_en, state);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if (cnt_en !== 1'b0 || s1 !== 1'b1 || state !== 2'b00 || s0 !== 1'b1) begin
         n_fail++;
         $display("FAIL midrun_reset: cnt_en=%b s1=%b st=%b s0=%b want 0 1 00 1",
                  cnt_en, s1, state, s0);
      end
      for (int k = 0; k < 6; k++) begin
         tick();
         n_checks++;
         if (cnt_en !== 1'b0 || state !== 2'b00) begin
            n_fail++;
            $display("FAIL midrun_idle k=%0d: cnt_en=%b st=%b", k, cnt_en, state);
         end
      end
      press(4'b0001);
      for (int k = 1; k <= 6; k++) begin
         tick();
         ee = (k == 5);
         n_checks++;
         if (cnt_en !== ee || state !== 2'b01) begin
            n_fail++;
            $display("FAIL midrun_rerun k=%0d: cnt_en=%b st=%b want %b 01",
                     k, cnt_en, state, ee);
         end
      end
      n_checks++;
      if (ctr !== 8'd1) begin
         n_fail++;
         $display("FAIL midrun_count: ctr=%0d want 1", ctr);
      end
   endtask

   initial begin
      rst = 1'b1;
      set_btns(4'b0000);
      test_reset();
      test_debounce();
      test_run_cadence();
      test_step_priority();
      test_dir_sel();
      test_reset_midrun();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
